// File: rtl/frac_quot_round_pkg.sv
// frac_quot_round_pkg: default widths and result record shared by the post-divide
// normalize/round stage, its rounding helper and anything that consumes the result.
// Latency: n/a (declarations only). Backpressure: n/a.
package frac_quot_round_pkg;

    localparam int NO  = 40;      // divider quotient fraction bits
    localparam int NR  = 32;      // rounded mantissa width
    localparam int EW  = 8;       // signed input exponent width
    localparam int EOW = EW + 2;  // result exponent: room for +1 normalize and +1 round carry

    typedef struct packed {
        logic [NR-1:0]         m;
        logic signed [EOW-1:0] e;
        logic                  inexact;
        logic                  err;
    } res_t;

endpackage

// File: rtl/frac_quot_round_rne.sv
// rne_round: combinational round-to-nearest-even of a normalized 0.1xxx fraction.
// Latency: 0 cycles (pure combinational). Backpressure: none, no state.
// Ports: norm (no+1 bits, MSB set) and e1 in; m (nr bits), e_out and inexact out.
module rne_round
    import frac_quot_round_pkg::*;
#(
    parameter int no  = NO,
    parameter int nr  = NR,
    parameter int eow = EOW
) (
    input  logic [no:0]           norm,
    input  logic signed [eow-1:0] e1,
    output logic [nr-1:0]         m,
    output logic signed [eow-1:0] e_out,
    output logic                  inexact
);

    logic [nr-1:0] mt;
    logic          g;
    logic          s;
    logic          rup;
    logic [nr:0]   sum;

    assign mt  = norm[no -: nr];
    assign g   = norm[no-nr];
    assign s   = |norm[no-nr-1:0];
    // Ties go up only when the kept LSB is odd.
    assign rup = g & (s | mt[0]);
    assign sum = {1'b0, mt} + {{nr{1'b0}}, rup};

    // A carry out of the mantissa means it was all ones: renormalize to 1000..0.
    assign m       = sum[nr] ? {1'b1, {(nr-1){1'b0}}} : sum[nr-1:0];
    assign e_out   = sum[nr] ? e1 + {{(eow-1){1'b0}}, 1'b1} : e1;
    assign inexact = g | s;

endmodule

// File: rtl/frac_quot_round.sv
// frac_quot_round: renormalize a divider quotient in [0.5,2) and RNE-round it to nr bits.
// Latency: 2 cycles (input transfer at edge N, out_valid after edge N+1); 1 result/cycle.
// Backpressure: valid/ready, 2 entries; stage 2 holds while out_valid & ~out_ready.
// Ports: in_valid/in_ready/q/e_in from the divider controller;
//        out_valid/out_ready/m/e_out/inexact/err to the consumer.
module frac_quot_round
    import frac_quot_round_pkg::*;
#(
    parameter int no = NO,
    parameter int nr = NR,
    parameter int ew = EW
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [no:0]         q,
    input  logic signed [ew-1:0] e_in,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [nr-1:0]       m,
    output logic signed [ew+1:0] e_out,
    output logic                inexact,
    output logic                err
);

    localparam int EOWL = ew + 2;

    // Need at least a guard bit and one sticky bit below the kept mantissa.
    generate
        if (no < nr + 2) begin : g_width_check
            $error("frac_quot_round: no must be at least nr+2");
        end
    endgenerate

    // Stage 1: normalized quotient
    logic                   s1_v_q, s1_v_d;
    logic [no:0]            norm_q, norm_d;
    logic signed [EOWL-1:0] e1_q, e1_d;
    logic                   err1_q, err1_d;

    // Stage 2: rounded result
    logic                   s2_v_q, s2_v_d;
    logic [nr-1:0]          m_q, m_d;
    logic signed [EOWL-1:0] e_q, e_d;
    logic                   inexact_q, inexact_d;
    logic                   err_q, err_d;

    logic                   s1_adv;
    logic                   in_xfer;
    logic signed [EOWL-1:0] e_in_x;
    logic [nr-1:0]          r_m;
    logic signed [EOWL-1:0] r_e;
    logic                   r_inexact;

    assign s1_adv   = s1_v_q & (~s2_v_q | out_ready);
    assign in_ready = ~s1_v_q | s1_adv;
    assign in_xfer  = in_valid & in_ready;
    assign e_in_x   = {{2{e_in[ew-1]}}, e_in};

    rne_round #(
        .no  (no),
        .nr  (nr),
        .eow (EOWL)
    ) u_rne (
        .norm    (norm_q),
        .e1      (e1_q),
        .m       (r_m),
        .e_out   (r_e),
        .inexact (r_inexact)
    );

    always_comb begin
        s1_v_d    = s1_v_q;
        norm_d    = norm_q;
        e1_d      = e1_q;
        err1_d    = err1_q;
        s2_v_d    = s2_v_q;
        m_d       = m_q;
        e_d       = e_q;
        inexact_d = inexact_q;
        err_d     = err_q;

        if (in_xfer) begin
            s1_v_d = 1'b1;
            norm_d = q[no] ? q : {q[no-1:0], 1'b0};
            e1_d   = e_in_x + {{(EOWL-1){1'b0}}, q[no]};
            err1_d = ~q[no] & ~q[no-1];
        end else if (s1_adv) begin
            s1_v_d = 1'b0;
        end

        if (s1_adv) begin
            s2_v_d = 1'b1;
            if (err1_q) begin
                // Unnormalized input: flag it and zero the payload.
                m_d       = '0;
                e_d       = '0;
                inexact_d = 1'b0;
                err_d     = 1'b1;
            end else begin
                m_d       = r_m;
                e_d       = r_e;
                inexact_d = r_inexact;
                err_d     = 1'b0;
            end
        end else if (out_ready) begin
            s2_v_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_v_q    <= 1'b0;
            norm_q    <= '0;
            e1_q      <= '0;
            err1_q    <= 1'b0;
            s2_v_q    <= 1'b0;
            m_q       <= '0;
            e_q       <= '0;
            inexact_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            s1_v_q    <= s1_v_d;
            norm_q    <= norm_d;
            e1_q      <= e1_d;
            err1_q    <= err1_d;
            s2_v_q    <= s2_v_d;
            m_q       <= m_d;
            e_q       <= e_d;
            inexact_q <= inexact_d;
            err_q     <= err_d;
        end
    end

    assign out_valid = s2_v_q;
    assign m         = m_q;
    assign e_out     = e_q;
    assign inexact   = inexact_q;
    assign err       = err_q;

endmodule

// File: tb/tb_frac_quot_round.sv
// tb_frac_quot_round: directed vector table, backpressure/reset sequences and random
// traffic for frac_quot_round, scored against an arithmetic reference model.
// Latency/backpressure: bench only; every wait is a fixed number of cycles.
module tb_frac_quot_round;
    import frac_quot_round_pkg::*;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  in_valid;
    logic                  in_ready;
    logic [NO:0]           q;
    logic signed [EW-1:0]  e_in;
    logic                  out_valid;
    logic                  out_ready;
    logic [NR-1:0]         m;
    logic signed [EOW-1:0] e_out;
    logic                  inexact;
    logic                  err;

    int   n_tests = 0;
    int   n_fail  = 0;
    int   n_in    = 0;
    int   n_out   = 0;
    res_t exp_q[$];

    typedef struct {
        string       name;
        logic [NO:0] q;
        int          e_in;
        logic [31:0] m;
        int          e_out;
        logic        inexact;
        logic        err;
    } vec_t;

    vec_t tbl[$];

    frac_quot_round dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .q         (q),
        .e_in      (e_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .m         (m),
        .e_out     (e_out),
        .inexact   (inexact),
        .err       (err)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference: value-level rounding of the quotient, not a copy of the bit slicing.
    function automatic res_t ref_model(logic [NO:0] qv, int ei);
        res_t            r;
        longint unsigned norm;
        longint unsigned mant;
        longint unsigned rem;
        longint unsigned half;
        int              e;
        r = '0;
        if (qv[NO:NO-1] == 2'b00) begin
            r.err = 1'b1;
            return r;
        end
        if (qv[NO]) begin
            norm = 64'(qv);
            e    = ei + 1;
        end else begin
            norm = 64'(qv) * 2;
            e    = ei;
        end
        mant = norm >> (NO + 1 - NR);
        rem  = norm % (64'd1 << (NO + 1 - NR));
        half = 64'd1 << (NO - NR);
        if (rem > half || (rem == half && mant[0])) mant = mant + 1;
        if (mant == (64'd1 << NR)) begin
            mant = 64'd1 << (NR - 1);
            e    = e + 1;
        end
        r.m       = NR'(mant);
        r.e       = EOW'(e);
        r.inexact = (rem != 0);
        return r;
    endfunction

    function automatic logic [NO:0] rand_q();
        logic [NO:0] v;
        int          mode;
        v    = (NO+1)'({$urandom(), $urandom()});
        mode = int'($urandom_range(0, 7));
        if (v[NO:NO-1] == 2'b00) v[NO-1] = 1'b1;
        case (mode)
            0: v[NO:NO-1] = 2'b00;
            1: if (v[NO]) v[8:0] = 9'h100; else v[7:0] = 8'h80;
            2: v[NO:8] = '1;
            default: ;
        endcase
        return v;
    endfunction

    function automatic vec_t mk(string n, logic [NO:0] qv, int ei, logic [31:0] mv,
                                int eo, logic ix, logic er);
        vec_t v;
        v.name = n; v.q = qv; v.e_in = ei; v.m = mv;
        v.e_out = eo; v.inexact = ix; v.err = er;
        return v;
    endfunction

    task automatic chk(string name, longint act, longint exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // One clock: score handshakes on the falling edge, return 1 time unit after the rising edge.
    task automatic tick();
        res_t r;
        @(negedge clk);
        if (!rst) begin
            if (out_valid && out_ready) begin
                n_out++;
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL sb_unexpected: output m=%0h with no pending entry", m);
                end else begin
                    r = exp_q.pop_front();
                    chk("sb_m", longint'(m), longint'(r.m));
                    chk("sb_e", longint'(e_out), longint'($signed(r.e)));
                    chk("sb_inexact", longint'(inexact), longint'(r.inexact));
                    chk("sb_err", longint'(err), longint'(r.err));
                end
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(ref_model(q, int'(e_in)));
                n_in++;
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [NR-1:0] m_hold;

        tbl.push_back(mk("exact_int",   41'h100_0000_0000,    0, 32'h8000_0000,    1, 1'b0, 1'b0));
        tbl.push_back(mk("exact_shift", 41'h0C0_0000_0000,   -3, 32'hC000_0000,   -3, 1'b0, 1'b0));
        tbl.push_back(mk("tie_odd",     41'h080_0000_0180,    0, 32'h8000_0002,    0, 1'b1, 1'b0));
        tbl.push_back(mk("tie_even",    41'h080_0000_0080,    0, 32'h8000_0000,    0, 1'b1, 1'b0));
        tbl.push_back(mk("tie_sticky",  41'h080_0000_0081,    0, 32'h8000_0001,    0, 1'b1, 1'b0));
        tbl.push_back(mk("round_ovf",   41'h1FF_FFFF_FF00,    5, 32'h8000_0000,    7, 1'b1, 1'b0));
        tbl.push_back(mk("max_ovf",     41'h1FF_FFFF_FFFF,  127, 32'h8000_0000,  129, 1'b1, 1'b0));
        tbl.push_back(mk("e_min",       41'h0C0_0000_0000, -128, 32'hC000_0000, -128, 1'b0, 1'b0));
        tbl.push_back(mk("sticky_only", 41'h100_0000_0001,    0, 32'h8000_0000,    1, 1'b1, 1'b0));
        tbl.push_back(mk("bad_input",   41'h040_0000_0000,   12, 32'h0000_0000,    0, 1'b0, 1'b1));

        // Reset state
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; q = '0; e_in = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", longint'(out_valid), 0);
        chk("rst_m", longint'(m), 0);
        chk("rst_e", longint'(e_out), 0);
        chk("rst_inexact", longint'(inexact), 0);
        chk("rst_err", longint'(err), 0);
        rst = 1'b0;
        #1;
        chk("rst_in_ready", longint'(in_ready), 1);
        tick();

        // Directed table: one transfer each, checking latency and result
        foreach (tbl[i]) begin
            q = tbl[i].q; e_in = EW'(tbl[i].e_in); in_valid = 1'b1; out_ready = 1'b1;
            #1;
            chk({tbl[i].name, "_in_ready"}, longint'(in_ready), 1);
            tick();
            in_valid = 1'b0; q = rand_q();
            chk({tbl[i].name, "_lat1"}, longint'(out_valid), 0);
            tick();
            chk({tbl[i].name, "_valid"}, longint'(out_valid), 1);
            chk({tbl[i].name, "_m"}, longint'(m), longint'(tbl[i].m));
            chk({tbl[i].name, "_e"}, longint'(e_out), longint'(tbl[i].e_out));
            chk({tbl[i].name, "_inexact"}, longint'(inexact), longint'(tbl[i].inexact));
            chk({tbl[i].name, "_err"}, longint'(err), longint'(tbl[i].err));
            tick();
        end

        // Backpressure: capacity of two, third input stalled until output drains
        out_ready = 1'b0; in_valid = 1'b1;
        q = rand_q(); e_in = EW'($urandom); #1;
        chk("bp_ready_0", longint'(in_ready), 1);
        tick();
        q = rand_q(); e_in = EW'($urandom); #1;
        chk("bp_ready_1", longint'(in_ready), 1);
        tick();
        q = rand_q(); e_in = EW'($urandom); #1;
        chk("bp_ready_2", longint'(in_ready), 0);
        tick();
        chk("bp_ready_3", longint'(in_ready), 0);
        chk("bp_valid", longint'(out_valid), 1);
        m_hold = m;
        tick();
        chk("bp_stable", longint'(m), longint'(m_hold));
        out_ready = 1'b1; #1;
        chk("bp_release", longint'(in_ready), 1);
        tick();
        in_valid = 1'b0;
        repeat (4) tick();
        chk("bp_drain_q", longint'(exp_q.size()), 0);
        chk("bp_count", longint'(n_out), longint'(n_in));

        // Continuous stream: one result per cycle
        out_ready = 1'b1; in_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            q = rand_q(); e_in = EW'($urandom); #1;
            chk("stream_ready", longint'(in_ready), 1);
            tick();
            if (i >= 1) chk("stream_valid", longint'(out_valid), 1);
        end
        in_valid = 1'b0;
        repeat (4) tick();
        chk("stream_count", longint'(n_out), longint'(n_in));

        // Reset with two entries in flight
        out_ready = 1'b0; in_valid = 1'b1;
        q = rand_q(); e_in = EW'($urandom);
        tick();
        q = rand_q(); e_in = EW'($urandom);
        tick();
        in_valid = 1'b0;
        chk("rst_mid_pre_valid", longint'(out_valid), 1);
        rst = 1'b1;
        #1;
        exp_q.delete();
        chk("rst_mid_valid", longint'(out_valid), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("rst_mid_in_ready", longint'(in_ready), 1);
        chk("rst_mid_m", longint'(m), 0);
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("rst_no_stale", longint'(out_valid), 0);
        end
        n_in = 0; n_out = 0;

        // Random traffic against the reference model
        for (int i = 0; i < 400; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            q = rand_q(); e_in = EW'($urandom);
            tick();
        end
        in_valid = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick();
        chk("rand_drain_q", longint'(exp_q.size()), 0);
        chk("rand_count", longint'(n_out), longint'(n_in));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
